// File: rtl/nios_hps_system_pio_pkg.sv
// Shared constants for the edge-capturing PIO input block:
// register map, edge-mode encodings and counter sizing.
package nios_hps_system_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    function automatic int cnt_width(input int cycles);
        return (cycles > 0) ? $clog2(cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/nios_hps_system_pio_debounce.sv
// One input bit: synchroniser chain followed by a stable-count debouncer.
// A zero cycle count reduces the debouncer to a single register.
module nios_hps_system_pio_debounce
    import nios_hps_system_pio_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic in_bit,
    output logic deb_q
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_q;

    // Shift the asynchronous input through the synchroniser chain
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], in_bit};
        end
    end

    assign sync_q = sync_r[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            // No filtering: one register after the synchroniser
            always_ff @(posedge clk) begin
                if (reset) begin
                    deb_q <= 1'b0;
                end else begin
                    deb_q <= sync_q;
                end
            end
        end else begin : g_count
            logic [CW-1:0] cnt;

            // Count consecutive disagreement; accept the new level on the last count
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt   <= '0;
                    deb_q <= 1'b0;
                end else if (sync_q == deb_q) begin
                    cnt <= '0;
                end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    cnt   <= '0;
                    deb_q <= sync_q;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/nios_hps_system_pio_in_edge.sv
// Avalon-MM PIO input port with synchronise, debounce, edge capture
// (write-one-to-clear), interrupt mask and a registered read path.
module nios_hps_system_pio_in_edge
    import nios_hps_system_pio_pkg::*;
#(
    parameter int DATA_WIDTH      = 10,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_MODE       = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [31:0]           readdata,
    output logic                  irq
);

    logic [DATA_WIDTH-1:0] deb_q;
    logic [DATA_WIDTH-1:0] prev_q;
    logic [DATA_WIDTH-1:0] edge_hit;
    logic [DATA_WIDTH-1:0] irqmask;
    logic [DATA_WIDTH-1:0] edgecap;
    logic [DATA_WIDTH-1:0] w1c;
    logic                  wr_en;

    genvar i;
    generate
        for (i = 0; i < DATA_WIDTH; i++) begin : g_bit
            nios_hps_system_pio_debounce #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .clk   (clk),
                .reset (reset),
                .in_bit(in_port[i]),
                .deb_q (deb_q[i])
            );
        end

        if (DATA_WIDTH < 32) begin : g_pad
            logic unused_wd;
            assign unused_wd = |writedata[31:DATA_WIDTH];
        end
    endgenerate

    assign wr_en = chipselect & ~write_n;
    assign w1c   = (wr_en && address == ADDR_EDGECAP) ?
                   writedata[DATA_WIDTH-1:0] : '0;

    // Select which debounced transitions count as events
    always_comb begin
        edge_hit = '0;
        case (EDGE_MODE)
            EDGE_FALL: edge_hit = prev_q & ~deb_q;
            EDGE_ANY:  edge_hit = prev_q ^ deb_q;
            default:   edge_hit = deb_q & ~prev_q;
        endcase
    end

    // Remember last cycle's debounced level for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= '0;
        end else begin
            prev_q <= deb_q;
        end
    end

    // Interrupt mask register
    always_ff @(posedge clk) begin
        if (reset) begin
            irqmask <= '0;
        end else if (wr_en && address == ADDR_IRQMASK) begin
            irqmask <= writedata[DATA_WIDTH-1:0];
        end
    end

    // Sticky edge flags; a new edge wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset) begin
            edgecap <= '0;
        end else begin
            edgecap <= (edgecap & ~w1c) | edge_hit;
        end
    end

    // Registered read mux, sees register values from before any same-cycle write
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            unique case (address)
                ADDR_DATA:    readdata <= 32'(deb_q);
                ADDR_IRQMASK: readdata <= 32'(irqmask);
                ADDR_EDGECAP: readdata <= 32'(edgecap);
                default:      readdata <= '0;
            endcase
        end
    end

    assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_nios_hps_system_pio_in_edge.sv
// Bench for the edge-capturing PIO: directed scenarios plus random traffic
// against a sliding-window behavioural model, on two configurations.
module tb_nios_hps_system_pio_in_edge;

    localparam int S = 2;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst [2];
    logic [1:0]  adr [2];
    logic        cs  [2];
    logic        wn  [2];
    logic [31:0] wd  [2];
    logic [31:0] pin [2];

    logic [31:0] rd_a, rd_b;
    logic        irq_a, irq_b;
    logic [31:0] rd_v [2];
    logic        irq_v [2];

    assign rd_v[0]  = rd_a;
    assign rd_v[1]  = rd_b;
    assign irq_v[0] = irq_a;
    assign irq_v[1] = irq_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    nios_hps_system_pio_in_edge #(
        .DATA_WIDTH(10), .SYNC_STAGES(S),
        .DEBOUNCE_CYCLES(D), .EDGE_MODE(0)
    ) dut_a (
        .clk(clk), .reset(rst[0]), .address(adr[0]),
        .chipselect(cs[0]), .write_n(wn[0]),
        .writedata(wd[0]), .in_port(pin[0][9:0]),
        .readdata(rd_a), .irq(irq_a)
    );

    nios_hps_system_pio_in_edge #(
        .DATA_WIDTH(32), .SYNC_STAGES(S),
        .DEBOUNCE_CYCLES(D), .EDGE_MODE(2)
    ) dut_b (
        .clk(clk), .reset(rst[1]), .address(adr[1]),
        .chipselect(cs[1]), .write_n(wn[1]),
        .writedata(wd[1]), .in_port(pin[1]),
        .readdata(rd_b), .irq(irq_b)
    );

    // ---------------- reference model ----------------
    // hist[k][j]: input word sampled j edges ago (0 = newest).
    // A debounced bit flips once the last D synchronised samples
    // all disagree with it.
    logic [31:0] hist [2][16];
    logic [31:0] m_deb [2];
    logic [31:0] m_debd [2];
    logic [31:0] m_ec [2];
    logic [31:0] m_mask [2];
    logic [31:0] m_rd [2];

    function automatic logic [31:0] wmask(input int k);
        return (k == 0) ? 32'h0000_03FF : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] deb_next(input int k);
        logic [31:0] hi;
        logic [31:0] lo;
        hi = '1;
        lo = '0;
        if (D == 0) return hist[k][S-1];
        for (int j = S - 1; j <= S + D - 2; j++) begin
            hi &= hist[k][j];
            lo |= hist[k][j];
        end
        return (m_deb[k] & lo) | (~m_deb[k] & hi);
    endfunction

    function automatic logic [31:0] edges(input int k);
        if (k == 0) return m_deb[k] & ~m_debd[k];
        return m_deb[k] ^ m_debd[k];
    endfunction

    function automatic logic [31:0] rd_next(input int k);
        case (adr[k])
            2'd0:    return m_deb[k];
            2'd2:    return m_mask[k];
            2'd3:    return m_ec[k];
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] clr_of(input int k);
        if (cs[k] && !wn[k] && adr[k] == 2'd3) return wd[k] & wmask(k);
        return 32'h0;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst[k]) begin
                for (int j = 0; j < 16; j++) hist[k][j] <= '0;
                m_deb[k]  <= '0;
                m_debd[k] <= '0;
                m_ec[k]   <= '0;
                m_mask[k] <= '0;
                m_rd[k]   <= '0;
            end else begin
                for (int j = 15; j > 0; j--) hist[k][j] <= hist[k][j-1];
                hist[k][0] <= pin[k] & wmask(k);
                m_deb[k]   <= deb_next(k);
                m_debd[k]  <= m_deb[k];
                m_rd[k]    <= rd_next(k);
                if (cs[k] && !wn[k] && adr[k] == 2'd2)
                    m_mask[k] <= wd[k] & wmask(k);
                m_ec[k] <= (m_ec[k] & ~clr_of(k)) | edges(k);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input int k, input logic [1:0] a,
                             input logic [31:0] d);
        adr[k] = a;
        cs[k]  = 1'b1;
        wn[k]  = 1'b0;
        wd[k]  = d;
        tick();
        cs[k]  = 1'b0;
        wn[k]  = 1'b1;
        wd[k]  = '0;
    endtask

    task automatic bus_read(input int k, input logic [1:0] a,
                            output logic [31:0] v);
        adr[k] = a;
        tick();
        v = rd_v[k];
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; adr[k] = 2'd3; cs[k] = 1'b0;
            wn[k] = 1'b1; wd[k] = '0; pin[k] = '0;
        end
        tick(3);
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (rd_v[k] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_rd[%0d]: got %h want 0", k, rd_v[k]);
            end
            n_tests++;
            if (irq_v[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_irq[%0d]: got %b want 0", k, irq_v[k]);
            end
            rst[k] = 1'b0;
        end
        tick(2);
    endtask

    task automatic test_basic_rise();
        logic [31:0] v;
        bus_write(0, 2'd2, 32'h1);
        adr[0] = 2'd0;
        pin[0] = 32'h1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i == 6) begin
                n_tests++;
                if (rd_a !== 32'h0 || irq_a !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rise_e6: rd %h irq %b want 0 0", rd_a, irq_a);
                end
            end
            if (i == 7) begin
                n_tests++;
                if (rd_a !== 32'h1 || irq_a !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rise_e7: rd %h irq %b want 1 1", rd_a, irq_a);
                end
            end
        end
        bus_read(0, 2'd3, v);
        n_tests++;
        if (v !== 32'h1) begin
            n_fail++;
            $display("FAIL rise_edgecap: got %h want 00000001", v);
        end
    endtask

    task automatic test_glitch();
        logic [31:0] v;
        bus_write(0, 2'd2, 32'h8);
        bus_write(0, 2'd3, 32'h1);
        pin[0] = 32'h9;
        tick(3);
        pin[0] = 32'h1;
        adr[0] = 2'd0;
        tick(15);
        n_tests++;
        if (rd_a !== 32'h1) begin
            n_fail++;
            $display("FAIL glitch_data: got %h want 00000001", rd_a);
        end
        bus_read(0, 2'd3, v);
        n_tests++;
        if (v !== 32'h0 || irq_a !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_cap: ec %h irq %b want 0 0", v, irq_a);
        end
    endtask

    task automatic test_w1c_edge();
        logic [31:0] v;
        pin[0] = 32'h0;
        tick(10);
        bus_write(0, 2'd3, 32'hFFFF_FFFF);
        bus_write(0, 2'd2, 32'h5);
        pin[0] = 32'h5;
        tick(10);
        bus_read(0, 2'd3, v);
        n_tests++;
        if (v !== 32'h5 || irq_a !== 1'b1) begin
            n_fail++;
            $display("FAIL w1c_setup: ec %h irq %b want 5 1", v, irq_a);
        end
        pin[0] = 32'h1;
        tick(10);
        pin[0] = 32'h5;
        tick(6);
        bus_write(0, 2'd3, 32'h4);
        n_tests++;
        if (rd_a !== 32'h5) begin
            n_fail++;
            $display("FAIL w1c_prewrite_read: got %h want 5", rd_a);
        end
        bus_read(0, 2'd3, v);
        n_tests++;
        if (v !== 32'h5 || irq_a !== 1'b1) begin
            n_fail++;
            $display("FAIL w1c_set_priority: ec %h irq %b want 5 1", v, irq_a);
        end
        bus_write(0, 2'd3, 32'h5);
        n_tests++;
        if (irq_a !== 1'b0) begin
            n_fail++;
            $display("FAIL w1c_irq_clear: got %b want 0", irq_a);
        end
        bus_read(0, 2'd3, v);
        n_tests++;
        if (v !== 32'h0) begin
            n_fail++;
            $display("FAIL w1c_clear: got %h want 0", v);
        end
    endtask

    task automatic test_any_edge();
        logic [31:0] v;
        pin[1] = 32'hFFFF_FFFF;
        tick(10);
        bus_read(1, 2'd3, v);
        n_tests++;
        if (v !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL any_rise: got %h want ffffffff", v);
        end
        bus_write(1, 2'd3, 32'hFFFF_FFFF);
        bus_read(1, 2'd3, v);
        n_tests++;
        if (v !== 32'h0) begin
            n_fail++;
            $display("FAIL any_clear: got %h want 0", v);
        end
        pin[1] = 32'h0;
        tick(10);
        bus_read(1, 2'd3, v);
        n_tests++;
        if (v !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL any_fall: got %h want ffffffff", v);
        end
        bus_read(1, 2'd0, v);
        n_tests++;
        if (v !== 32'h0) begin
            n_fail++;
            $display("FAIL any_data: got %h want 0", v);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp;
        pin[0] = 32'h0;
        tick(10);
        bus_write(0, 2'd3, 32'hFFFF_FFFF);
        pin[0] = 32'h10;
        tick(10);
        bus_write(0, 2'd2, 32'h3FF);
        n_tests++;
        if (irq_a !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_pre_irq: got %b want 1", irq_a);
        end
        pin[0] = 32'h12;
        tick(4);
        rst[0] = 1'b1;
        tick(2);
        n_tests++;
        if (rd_a !== 32'h0 || irq_a !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_in_reset: rd %h irq %b want 0 0", rd_a, irq_a);
        end
        rst[0] = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            adr[0] = (t <= 2) ? 2'd2 : (t <= 4) ? 2'd0 : 2'd3;
            tick();
            exp = (t == 8) ? 32'h12 : 32'h0;
            if (t == 2 || t == 4 || t >= 7) begin
                n_tests++;
                if (rd_a !== exp) begin
                    n_fail++;
                    $display("FAIL rmid_t%0d: got %h want %h", t, rd_a, exp);
                end
            end
        end
    endtask

    task automatic test_reserved_padding();
        logic [31:0] v;
        bus_write(0, 2'd0, 32'hFFFF_FFFF);
        bus_write(0, 2'd1, 32'hFFFF_FFFF);
        bus_read(0, 2'd1, v);
        n_tests++;
        if (v !== 32'h0) begin
            n_fail++;
            $display("FAIL rsvd_read: got %h want 0", v);
        end
        bus_read(0, 2'd0, v);
        n_tests++;
        if (v !== 32'h12) begin
            n_fail++;
            $display("FAIL data_unchanged: got %h want 12", v);
        end
        bus_write(0, 2'd2, 32'hFFFF_FFFF);
        bus_read(0, 2'd2, v);
        n_tests++;
        if (v !== 32'h3FF) begin
            n_fail++;
            $display("FAIL mask_width: got %h want 3ff", v);
        end
        for (int a = 0; a < 4; a++) begin
            bus_read(0, 2'(a), v);
            n_tests++;
            if (v[31:10] !== 22'h0) begin
                n_fail++;
                $display("FAIL pad_addr%0d: got %h want upper 0", a, v);
            end
        end
    endtask

    task automatic test_random();
        int hold [2];
        hold[0] = 0;
        hold[1] = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (hold[k] == 0) begin
                    pin[k] = pin[k] ^ ($urandom() & $urandom());
                    hold[k] = $urandom_range(1, 12);
                end
                hold[k]--;
                adr[k] = 2'($urandom_range(0, 3));
                cs[k]  = ($urandom_range(0, 3) == 0);
                wn[k]  = ($urandom_range(0, 1) == 0);
                wd[k]  = $urandom();
                rst[k] = ($urandom_range(0, 199) == 0);
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (rd_v[k] !== m_rd[k]) begin
                    n_fail++;
                    $display("FAIL rand_rd[%0d] cyc %0d: got %h want %h",
                             k, c, rd_v[k], m_rd[k]);
                end
                n_tests++;
                if (irq_v[k] !== (|(m_ec[k] & m_mask[k]))) begin
                    n_fail++;
                    $display("FAIL rand_irq[%0d] cyc %0d: got %b want %b",
                             k, c, irq_v[k], |(m_ec[k] & m_mask[k]));
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b0;
            cs[k]  = 1'b0;
            wn[k]  = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_basic_rise();
        test_glitch();
        test_w1c_edge();
        test_any_edge();
        test_reset_mid();
        test_reserved_padding();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
